// File: rtl/matmul_seq.sv
// matmul_seq: buffers one A/B tile, drives a matmul array, streams result rows.
// Define MATMUL_SEQ_PERF_CNT_EN to add tile_cnt/stall_cnt outputs.
module matmul_seq #(
    parameter int N          = 4,
    parameter int W          = 16,
    parameter int CLR_CYCLES = 4,
    parameter int DRAIN_LAT  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_a,
    input  logic [N*W-1:0] in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_row,
    output logic           out_last,
    output logic           busy,
    output logic [1:0]     mm_op,
    output logic [N*W-1:0] mm_a,
    output logic [N*W-1:0] mm_b,
    input  logic [N*W-1:0] mm_c
`ifdef MATMUL_SEQ_PERF_CNT_EN
   ,output logic [31:0]    tile_cnt,
    output logic [31:0]    stall_cnt
`endif
);
    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_CAPT  = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_CALC = 2'b10;

    localparam int CW = $clog2(N + CLR_CYCLES + DRAIN_LAT + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] C_N1   = CW'(N - 1);
    localparam logic [CW-1:0] C_CLR1 = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] C_DL1  = CW'((DRAIN_LAT > 0) ? DRAIN_LAT - 1 : 0);
    // With zero drain latency row 0 is already valid on the first NOP cycle.
    localparam logic [2:0] S_POSTFEED = (DRAIN_LAT > 0) ? S_DRAIN : S_CAPT;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [CW-1:0]         w_lim;
    logic                  r_in_ready;
    logic [1:0]            r_op;
    logic [1:0]            w_op_nxt;
    logic [N*W-1:0]        r_mm_a;
    logic [N*W-1:0]        r_mm_b;
    logic [N-1:0][N*W-1:0] r_ibuf_a;
    logic [N-1:0][N*W-1:0] r_ibuf_b;
    logic [N-1:0][N*W-1:0] r_rbuf;
    logic                  w_acc;
    logic                  w_hs;
    logic                  w_step;
    logic                  w_done;
    logic [IW-1:0]         w_idx;
    logic [IW-1:0]         w_nidx;

    assign w_acc  = in_valid && r_in_ready;
    assign w_hs   = out_valid && out_ready;
    assign w_idx  = r_cnt[IW-1:0];
    assign w_nidx = w_cnt_nxt[IW-1:0];

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state == S_OUT);
    assign out_row   = out_valid ? r_rbuf[w_idx] : '0;
    assign out_last  = out_valid && (r_cnt == C_N1);
    assign busy      = !((r_state == S_LOAD) && (r_cnt == '0));
    assign mm_op     = r_op;
    assign mm_a      = r_mm_a;
    assign mm_b      = r_mm_b;

    // One counter serves every state; only its limit and step enable differ.
    always_comb begin
        w_lim  = C_N1;
        w_step = 1'b1;
        case (r_state)
            S_LOAD:  w_step = w_acc;
            S_CLEAR: w_lim  = C_CLR1;
            S_DRAIN: w_lim  = C_DL1;
            S_OUT:   w_step = w_hs;
            default: w_lim  = C_N1;
        endcase
        w_done = w_step && (r_cnt == w_lim);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_step) begin
            w_cnt_nxt = w_done ? '0 : r_cnt + 1'b1;
        end
        if (w_done) begin
            case (r_state)
                S_LOAD:  w_state_nxt = S_CLEAR;
                S_CLEAR: w_state_nxt = S_FEED;
                S_FEED:  w_state_nxt = S_POSTFEED;
                S_DRAIN: w_state_nxt = S_CAPT;
                S_CAPT:  w_state_nxt = S_OUT;
                default: w_state_nxt = S_LOAD;
            endcase
        end
        w_op_nxt = OP_NOP;
        if (w_state_nxt == S_CLEAR) begin
            w_op_nxt = OP_CLR;
        end else if (w_state_nxt == S_FEED) begin
            w_op_nxt = OP_CALC;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_LOAD;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_op       <= OP_NOP;
            r_mm_a     <= '0;
            r_mm_b     <= '0;
            r_ibuf_a   <= '0;
            r_ibuf_b   <= '0;
            r_rbuf     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_in_ready <= (w_state_nxt == S_LOAD);
            r_op       <= w_op_nxt;
            r_mm_a     <= (w_state_nxt == S_FEED) ? r_ibuf_a[w_nidx] : '0;
            r_mm_b     <= (w_state_nxt == S_FEED) ? r_ibuf_b[w_nidx] : '0;
            if ((r_state == S_LOAD) && w_acc) begin
                r_ibuf_a[w_idx] <= in_a;
                r_ibuf_b[w_idx] <= in_b;
            end
            if (r_state == S_CAPT) begin
                r_rbuf[w_idx] <= mm_c;
            end
        end
    end

`ifdef MATMUL_SEQ_PERF_CNT_EN
    logic [31:0] r_tile_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tile_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_hs && out_last) begin
                r_tile_cnt <= r_tile_cnt + 32'd1;
            end
            if (out_valid && !out_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign tile_cnt  = r_tile_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: random and directed tiles against a matrix-product model,
// with a behavioural matmul array answering on mm_c.
`timescale 1ns/1ps
module tb_matmul_seq;
    localparam int N   = 4;
    localparam int W   = 16;
    localparam int CLR = 4;
    localparam int DL  = 1;
    localparam int LW  = N * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] in_a;
    logic [LW-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_row;
    logic          out_last;
    logic          busy;
    logic [1:0]    mm_op;
    logic [LW-1:0] mm_a;
    logic [LW-1:0] mm_b;
    logic [LW-1:0] mm_c = '0;
`ifdef MATMUL_SEQ_PERF_CNT_EN
    logic [31:0]   tile_cnt;
    logic [31:0]   stall_cnt;
`endif

    matmul_seq #(.N(N), .W(W), .CLR_CYCLES(CLR), .DRAIN_LAT(DL)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last),
        .busy      (busy),
        .mm_op     (mm_op),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_c      (mm_c)
`ifdef MATMUL_SEQ_PERF_CNT_EN
       ,.tile_cnt  (tile_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int exp_tiles = 0;
    int exp_stalls = 0;

    logic [LW-1:0] cur_a [N];
    logic [LW-1:0] cur_b [N];
    logic [LW-1:0] exp_row [N];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural array: CLEAR zeroes, CALC adds outer(a,b),
    // row r appears DL+r cycles after the first NOP; junk otherwise.
    logic [W-1:0] acc [N][N];
    int dk = -1;
    always @(posedge clk) begin
        logic [LW-1:0] row;
        case (mm_op)
            2'b01: begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) acc[i][j] = '0;
                dk = -1;
            end
            2'b10: begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        acc[i][j] = acc[i][j] + mm_a[i*W+:W] * mm_b[j*W+:W];
                dk = 0;
            end
            default: if (dk >= 0 && dk < 100) dk++;
        endcase
        row = {$urandom, $urandom};
        if (dk >= DL && dk < DL + N)
            for (int j = 0; j < N; j++) row[j*W+:W] = acc[dk-DL][j];
        mm_c <= row;
    end

    // Feed monitor: CLR clears directly before N contiguous CALC beats.
    int feed_i = 0;
    int clr_run = 0;
    logic [1:0] prev_op = 2'b00;
    always @(posedge clk) begin
        if (!rst) begin
            feed_i = 0;
            clr_run = 0;
            prev_op = 2'b00;
        end else begin
            if (mm_op == 2'b01) clr_run = (prev_op == 2'b01) ? clr_run + 1 : 1;
            if (mm_op == 2'b10) begin
                if (feed_i == 0) check("clr_len", 64'(clr_run), 64'(CLR));
                else check("feed_gap", 64'(prev_op), 64'(2'b10));
                if (feed_i < N) begin
                    check("mm_a", mm_a, cur_a[feed_i]);
                    check("mm_b", mm_b, cur_b[feed_i]);
                end
                feed_i++;
            end else if (prev_op == 2'b10) begin
                check("feed_len", 64'(feed_i), 64'(N));
                feed_i = 0;
            end
            if (mm_op == 2'b00) clr_run = 0;
            prev_op = mm_op;
        end
    end

    task automatic calc_exp();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int unsigned s;
                s = 0;
                for (int k = 0; k < N; k++)
                    s += 32'(cur_a[k][i*W+:W]) * 32'(cur_b[k][j*W+:W]);
                exp_row[i][j*W+:W] = s[W-1:0];
            end
    endtask

    task automatic set_directed();
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++) begin
                cur_a[k][i*W+:W] = W'(1 + k + 4 * i);
                cur_b[k][i*W+:W] = W'(17 + 4 * k + i);
            end
        exp_row[0] = {16'd280, 16'd270, 16'd260, 16'd250};
        exp_row[1] = {16'd696, 16'd670, 16'd644, 16'd618};
        exp_row[2] = {16'd1112, 16'd1070, 16'd1028, 16'd986};
        exp_row[3] = {16'd1528, 16'd1470, 16'd1412, 16'd1354};
    endtask

    task automatic set_random();
        for (int k = 0; k < N; k++) begin
            cur_a[k] = {$urandom, $urandom};
            cur_b[k] = {$urandom, $urandom};
        end
        calc_exp();
    endtask

    task automatic drive_tile(input bit gaps, input int nb);
        for (int k = 0; k < nb; k++) begin
            int t;
            if (gaps) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_a = cur_a[k];
            in_b = cur_b[k];
            t = 0;
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("in_ready", 64'(in_ready), 64'(1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
    endtask

    task automatic collect(input int srow, input int slen, input bit rnd,
                           input bit junk);
        for (int r = 0; r < N; r++) begin
            int t;
            int ns;
            t = 0;
            while (!out_valid && t < 200) begin
                if (junk) begin
                    in_valid = 1'b1;
                    in_a = {$urandom, $urandom};
                    in_b = {$urandom, $urandom};
                end
                @(negedge clk);
                t++;
            end
            check("out_valid", 64'(out_valid), 64'(1));
            ns = (r == srow) ? slen : (rnd ? int'($urandom_range(0, 3)) : 0);
            if (ns > 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < ns; s++) begin
                    @(negedge clk);
                    check("hold_row", out_row, exp_row[r]);
                    check("hold_rdy", 64'(in_ready), 64'(0));
                end
                out_ready = 1'b1;
            end
            exp_stalls += ns;
            check("row", out_row, exp_row[r]);
            check("last", 64'(out_last), 64'(r == N - 1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("done_valid", 64'(out_valid), 64'(0));
        check("done_rdy", 64'(in_ready), 64'(1));
        check("done_busy", 64'(busy), 64'(0));
        exp_tiles++;
    endtask

    task automatic check_rst_outs();
        check("rst_op", 64'(mm_op), 64'(0));
        check("rst_a", mm_a, 64'(0));
        check("rst_b", mm_b, 64'(0));
        check("rst_ovalid", 64'(out_valid), 64'(0));
        check("rst_row", out_row, 64'(0));
        check("rst_last", 64'(out_last), 64'(0));
        check("rst_irdy", 64'(in_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
    endtask

    task automatic rst_pulse();
        rst = 1'b0;
        #1;
        check_rst_outs();
        repeat (4) @(negedge clk);
        check_rst_outs();
        rst = 1'b1;
        exp_tiles = 0;
        exp_stalls = 0;
        @(negedge clk);
        check("rel_irdy", 64'(in_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int nc;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;
        #3;
        rst_pulse();

        set_directed();
        drive_tile(1'b0, N);
        collect(-1, 0, 1'b0, 1'b0);

        drive_tile(1'b1, N);
        collect(-1, 0, 1'b0, 1'b0);

        drive_tile(1'b0, N);
        collect(2, 5, 1'b0, 1'b0);

        drive_tile(1'b0, N);
        collect(-1, 0, 1'b0, 1'b0);
        drive_tile(1'b0, N);
        collect(-1, 0, 1'b0, 1'b0);

        drive_tile(1'b0, N);
        t = 0;
        nc = 0;
        while (nc < 3 && t < 200) begin
            @(negedge clk);
            if (mm_op == 2'b10) nc++;
            t++;
        end
        check("feed_seen", 64'(nc), 64'(3));
        rst_pulse();
        drive_tile(1'b0, N);
        collect(-1, 0, 1'b0, 1'b0);
`ifdef MATMUL_SEQ_PERF_CNT_EN
        check("tile_cnt1", 64'(tile_cnt), 64'(1));
        check("stall_cnt1", 64'(stall_cnt), 64'(0));
`endif

        set_random();
        drive_tile(1'b0, 2);
        rst_pulse();
        set_random();
        drive_tile(1'b1, N);
        collect(-1, 0, 1'b1, 1'b1);

        for (int n = 0; n < 20; n++) begin
            set_random();
            drive_tile(1'($urandom), N);
            collect(-1, 0, 1'b1, 1'b1);
        end
`ifdef MATMUL_SEQ_PERF_CNT_EN
        check("tile_cnt", 64'(tile_cnt), 64'(exp_tiles));
        check("stall_cnt", 64'(stall_cnt), 64'(exp_stalls));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/matmul_seq.md
Name: matmul_seq

Overview:
- Tile sequencer placed directly upstream of the 4x4 matmul array.
- Accepts one tile as N valid/ready beats. Each beat is one A column plus one B row.
- Buffers the tile, then drives the array's op/a/b pins: clear, N contiguous calculate beats, then nop to drain.
- Captures the N result rows from the array's c bus and returns them on a valid/ready output stream.

Parameters:
- N, 4, array dimension; beats per tile and rows per result.
- W, 16, element width; lanes are packed lane0 in bits [W-1:0].
- CLR_CYCLES, 4, cycles op=CLEAR is held before feeding.
- DRAIN_LAT, 1, cycles after the first NOP cycle before row 0 is valid on mm_c.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- in_a  in  N*W  A column
- in_b  in  N*W  B row
- out_valid  out  1  result row valid
- out_ready  in  1  consumer ready
- out_row  out  N*W  result row
- out_last  out  1  high with row N-1
- busy  out  1  tile in progress (any state except LOAD with cnt=0)
- mm_op  out  2  to array: 00 NOP, 01 CLEAR, 10 CALC
- mm_a  out  N*W  to array a
- mm_b  out  N*W  to array b
- mm_c  in  N*W  from array c

Behaviour:
- Reset (rst=0, async):
  - state=LOAD, cnt=0, mm_op=00, mm_a=mm_b=0.
  - out_valid=0, out_last=0, out_row=0, in_ready=0 while rst=0.
  - Tile and result buffers are cleared.
- Registered outputs: all mm_* outputs are registered. The value is presented for the full cycle the state occupies.
- LOAD:
  - in_ready=1.
  - Each accepted beat is written to ibuf[cnt] and cnt increments.
  - mm_op=00, mm_a=mm_b=0.
  - Gaps in in_valid are allowed and have no effect on the array.
  - On the N-th accept: cnt=0, go to CLEAR.
- CLEAR:
  - in_ready=0, mm_op=01 for exactly CLR_CYCLES cycles, then go to FEED.
  - Every tile is preceded by CLEAR. Accumulator state left in the array by earlier tiles or resets is therefore irrelevant.
- FEED:
  - N consecutive cycles with mm_op=10, mm_a=ibuf[k].a, mm_b=ibuf[k].b, for k=0..N-1.
  - No bubbles are permitted.
- DRAIN:
  - mm_op=00 (held through CAPTURE).
  - Wait DRAIN_LAT cycles, counted from the first NOP cycle.
- CAPTURE:
  - N cycles; cycle r samples mm_c into rbuf[r].
  - Row r is valid on mm_c DRAIN_LAT+r cycles after the first NOP cycle.
- OUT:
  - out_valid=1, out_row=rbuf[r], out_last=(r==N-1).
  - r advances on out_valid&&out_ready.
  - out_row is held stable while out_ready=0.
  - After the row N-1 handshake: out_valid=0, go to LOAD.
- Input side outside LOAD: in_ready=0 in every state other than LOAD. No overlap with the next tile.
- Arithmetic: the block only moves data; there are no width changes. Lanes pass through bit-exact.
- Async reset mid-operation:
  - All outputs return to reset values immediately and any partial tile is discarded.
  - The next tile after release starts with a full LOAD and CLEAR.
- Simultaneous events: in_valid during CLEAR/FEED/OUT is ignored (not accepted). out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro MATMUL_SEQ_PERF_CNT_EN.
- Defined: adds outputs tile_cnt[31:0] and stall_cnt[31:0], both reset to 0 asynchronously.
  - tile_cnt increments on the row N-1 output handshake.
  - stall_cnt increments each cycle out_valid&&!out_ready.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 for 4 cycles mid-random traffic -> mm_op=00, mm_a=mm_b=0, out_valid=0, in_ready=0, busy=0; in_ready=1 the cycle after release.
- Single tile, N=4, out_ready=1:
  - Beats are lane0-first: a = (1,5,9,13), (2,6,10,14), (3,7,11,15), (4,8,12,16); b = (17,18,19,20), (21..24), (25..28), (29..32).
  - Required mm_op: exactly 4 cycles of 01, then 4 contiguous cycles of 10.
  - Required out rows: (250,260,270,280), (618,644,670,696), (986,1028,1070,1112), (1354,1412,1470,1528); out_last on row 3 only.
- Same tile with in_valid toggled every other cycle -> mm_op still shows 4 contiguous CALC cycles; identical output rows.
- out_ready=0 for 5 cycles while row 2 is presented -> out_row holds 986..1112; in_ready=0 throughout; row 3 follows after out_ready=1.
- Two tiles back-to-back with identical data -> CLEAR precedes the second FEED; second result identical to the first (no accumulation across tiles).
- rst asserted during FEED beat 2 -> mm_op=00 with no clock edge; after release, one full tile yields the correct rows. With MATMUL_SEQ_PERF_CNT_EN: tile_cnt=1, stall_cnt=0.
